// File: rtl/calc1_port_sched.sv
// Round-robin scheduler sharing one calc1-style ALU between four two-cycle request ports.
// Define CALC1_SCHED_CMD_FILTER_EN to answer commands other than 1/2/5/6 locally without issuing them.
module calc1_port_sched #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ALU_TIMEOUT = 32
) (
  input  logic              c_clk,
  input  logic              reset,
  input  logic [3:0]        req1_cmd_in,
  input  logic [DATA_W-1:0] req1_data_in,
  input  logic [3:0]        req2_cmd_in,
  input  logic [DATA_W-1:0] req2_data_in,
  input  logic [3:0]        req3_cmd_in,
  input  logic [DATA_W-1:0] req3_data_in,
  input  logic [3:0]        req4_cmd_in,
  input  logic [DATA_W-1:0] req4_data_in,
  output logic [1:0]        out_resp1,
  output logic [DATA_W-1:0] out_data1,
  output logic [1:0]        out_resp2,
  output logic [DATA_W-1:0] out_data2,
  output logic [1:0]        out_resp3,
  output logic [DATA_W-1:0] out_data3,
  output logic [1:0]        out_resp4,
  output logic [DATA_W-1:0] out_data4,
  output logic              alu_start,
  output logic [3:0]        alu_cmd,
  output logic [DATA_W-1:0] alu_op1,
  output logic [DATA_W-1:0] alu_op2,
  input  logic              alu_done,
  input  logic [1:0]        alu_resp,
  input  logic [DATA_W-1:0] alu_result
);
  localparam int unsigned NPORT = 4;
  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {P_IDLE, P_OP2, P_PEND} port_state_t;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} sched_state_t;

  logic [3:0]        cmd_in  [NPORT];
  logic [DATA_W-1:0] data_in [NPORT];

  port_state_t       p_state     [NPORT];
  port_state_t       p_state_nxt [NPORT];
  logic [3:0]        p_cmd       [NPORT];
  logic [DATA_W-1:0] p_op1       [NPORT];
  logic [DATA_W-1:0] p_op2       [NPORT];

  sched_state_t      s_state, s_nxt;
  logic [1:0]        grant, grant_nxt, ptr, ptr_nxt, win, cand;
  logic              found, fwd;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              start_nxt;
  logic [3:0]        cmd_nxt;
  logic [DATA_W-1:0] op1_nxt, op2_nxt;
  logic [1:0]        resp_q    [NPORT];
  logic [1:0]        resp_nxt  [NPORT];
  logic [DATA_W-1:0] rdata_q   [NPORT];
  logic [DATA_W-1:0] rdata_nxt [NPORT];

  assign cmd_in[0]  = req1_cmd_in;
  assign cmd_in[1]  = req2_cmd_in;
  assign cmd_in[2]  = req3_cmd_in;
  assign cmd_in[3]  = req4_cmd_in;
  assign data_in[0] = req1_data_in;
  assign data_in[1] = req2_data_in;
  assign data_in[2] = req3_data_in;
  assign data_in[3] = req4_data_in;

  assign out_resp1 = resp_q[0];
  assign out_resp2 = resp_q[1];
  assign out_resp3 = resp_q[2];
  assign out_resp4 = resp_q[3];
  assign out_data1 = rdata_q[0];
  assign out_data2 = rdata_q[1];
  assign out_data3 = rdata_q[2];
  assign out_data4 = rdata_q[3];

  // Per-port capture FSM; a port is released in the cycle its response is driven.
  always_comb begin
    for (int i = 0; i < NPORT; i++) begin
      p_state_nxt[i] = p_state[i];
      case (p_state[i])
        P_IDLE:  if (cmd_in[i] != 4'd0) p_state_nxt[i] = P_OP2;
        P_OP2:   p_state_nxt[i] = P_PEND;
        P_PEND:  if (s_state == S_RESP && grant == 2'(i)) p_state_nxt[i] = P_IDLE;
        default: p_state_nxt[i] = P_IDLE;
      endcase
    end
  end

  always_ff @(posedge c_clk) begin
    if (reset) begin
      for (int i = 0; i < NPORT; i++) begin
        p_state[i] <= P_IDLE;
        p_cmd[i]   <= '0;
        p_op1[i]   <= '0;
        p_op2[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NPORT; i++) begin
        p_state[i] <= p_state_nxt[i];
        if (p_state[i] == P_IDLE && cmd_in[i] != 4'd0) begin
          p_cmd[i] <= cmd_in[i];
          p_op1[i] <= data_in[i];
        end
        if (p_state[i] == P_OP2) p_op2[i] <= data_in[i];
      end
    end
  end

  // Round-robin search starting one past the last granted port.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int k = 1; k <= 4; k++) begin
      cand = ptr + 2'(k);
      if (!found && p_state[cand] == P_PEND) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

`ifdef CALC1_SCHED_CMD_FILTER_EN
  assign fwd = p_cmd[win] inside {4'd1, 4'd2, 4'd5, 4'd6};
`else
  assign fwd = 1'b1;
`endif

  always_comb begin
    s_nxt     = s_state;
    grant_nxt = grant;
    ptr_nxt   = ptr;
    cnt_nxt   = cnt;
    start_nxt = 1'b0;
    cmd_nxt   = alu_cmd;
    op1_nxt   = alu_op1;
    op2_nxt   = alu_op2;
    for (int i = 0; i < NPORT; i++) begin
      resp_nxt[i]  = '0;
      rdata_nxt[i] = '0;
    end
    case (s_state)
      S_IDLE: begin
        if (found) begin
          grant_nxt = win;
          if (fwd) begin
            cmd_nxt   = p_cmd[win];
            op1_nxt   = p_op1[win];
            op2_nxt   = p_op2[win];
            start_nxt = 1'b1;
            s_nxt     = S_ISSUE;
          end else begin
            resp_nxt[win] = 2'd2;
            s_nxt         = S_RESP;
          end
        end
      end
      S_ISSUE: begin
        cnt_nxt = CNT_W'(1);
        s_nxt   = S_WAIT;
      end
      S_WAIT: begin
        cnt_nxt = cnt + CNT_W'(1);
        // A completion in the same cycle as the timeout takes precedence.
        if (alu_done) begin
          resp_nxt[grant]  = alu_resp;
          rdata_nxt[grant] = alu_result;
          s_nxt            = S_RESP;
        end else if (cnt == CNT_W'(ALU_TIMEOUT)) begin
          resp_nxt[grant] = 2'd3;
          s_nxt           = S_RESP;
        end
      end
      S_RESP: begin
        ptr_nxt = grant;
        s_nxt   = S_IDLE;
      end
      default: s_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge c_clk) begin
    if (reset) begin
      s_state   <= S_IDLE;
      grant     <= '0;
      ptr       <= 2'd3;
      cnt       <= '0;
      alu_start <= 1'b0;
      alu_cmd   <= '0;
      alu_op1   <= '0;
      alu_op2   <= '0;
      for (int i = 0; i < NPORT; i++) begin
        resp_q[i]  <= '0;
        rdata_q[i] <= '0;
      end
    end else begin
      s_state   <= s_nxt;
      grant     <= grant_nxt;
      ptr       <= ptr_nxt;
      cnt       <= cnt_nxt;
      alu_start <= start_nxt;
      alu_cmd   <= cmd_nxt;
      alu_op1   <= op1_nxt;
      alu_op2   <= op2_nxt;
      for (int i = 0; i < NPORT; i++) begin
        resp_q[i]  <= resp_nxt[i];
        rdata_q[i] <= rdata_nxt[i];
      end
    end
  end

endmodule

// File: tb/tb_calc1_port_sched.sv
// Self-checking bench for calc1_port_sched: behavioural ALU responder plus a round-robin order model.
`timescale 1ns/1ps
module tb_calc1_port_sched;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 20;

  typedef struct {
    int            port;
    logic [1:0]    resp;
    logic [DW-1:0] data;
    int            cyc;
  } obs_t;

  logic          c_clk = 1'b0;
  logic          reset = 1'b1;
  logic [3:0]    cmd_in   [4];
  logic [DW-1:0] data_in  [4];
  logic [1:0]    out_resp [4];
  logic [DW-1:0] out_data [4];
  logic          alu_start;
  logic [3:0]    alu_cmd;
  logic [DW-1:0] alu_op1, alu_op2;
  logic          alu_done;
  logic [1:0]    alu_resp;
  logic [DW-1:0] alu_result;

  int total = 0, bad = 0, cyc = 0;
  int alu_lat = 3;  // 0 means the ALU never completes
  int cd = 0, start_cnt = 0, start_cyc = 0;
  logic [3:0]    st_cmd = '0;
  logic [DW-1:0] st_op1 = '0, st_op2 = '0;
  obs_t obs_q [$];
  bit   mon_en = 1'b0;
  int   multi_viol = 0, idle_data_viol = 0;
  int   model_last = 3;
  logic [3:0]    req_cmd [4];
  logic [DW-1:0] req_a [4], req_b [4];

  calc1_port_sched #(.DATA_W(DW), .ALU_TIMEOUT(TO)) dut (
    .c_clk(c_clk), .reset(reset),
    .req1_cmd_in(cmd_in[0]), .req1_data_in(data_in[0]),
    .req2_cmd_in(cmd_in[1]), .req2_data_in(data_in[1]),
    .req3_cmd_in(cmd_in[2]), .req3_data_in(data_in[2]),
    .req4_cmd_in(cmd_in[3]), .req4_data_in(data_in[3]),
    .out_resp1(out_resp[0]), .out_data1(out_data[0]),
    .out_resp2(out_resp[1]), .out_data2(out_data[1]),
    .out_resp3(out_resp[2]), .out_data3(out_data[2]),
    .out_resp4(out_resp[3]), .out_data4(out_data[3]),
    .alu_start(alu_start), .alu_cmd(alu_cmd), .alu_op1(alu_op1), .alu_op2(alu_op2),
    .alu_done(alu_done), .alu_resp(alu_resp), .alu_result(alu_result)
  );

  always #5 c_clk = ~c_clk;
  always @(posedge c_clk) cyc <= cyc + 1;

  // Reference ALU behaviour: {resp, result}.
  function automatic logic [DW+1:0] alu_model(input logic [3:0] c, input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW:0] s;
    case (c)
      4'd1: begin
        s = {1'b0, a} + {1'b0, b};
        return {(s[DW] ? 2'd2 : 2'd1), s[DW-1:0]};
      end
      4'd2: return {((a < b) ? 2'd2 : 2'd1), a - b};
      default: return {2'd2, 32'hBAD0_0000 | {28'd0, c}};
    endcase
  endfunction

  // ALU responder: completes alu_lat cycles after each start pulse.
  initial begin
    alu_done = 1'b0; alu_resp = '0; alu_result = '0;
    forever begin
      @(negedge c_clk);
      alu_done = 1'b0; alu_resp = '0; alu_result = '0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          alu_done = 1'b1;
          {alu_resp, alu_result} = alu_model(st_cmd, st_op1, st_op2);
        end
      end
      if (alu_start === 1'b1) begin
        start_cnt++;
        start_cyc = cyc;
        st_cmd = alu_cmd; st_op1 = alu_op1; st_op2 = alu_op2;
        cd = alu_lat;
      end
    end
  end

  // Response monitor.
  always @(negedge c_clk) begin
    int n;
    obs_t o;
    n = 0;
    if (mon_en) begin
      for (int i = 0; i < 4; i++) begin
        if (out_resp[i] !== 2'd0) begin
          n++;
          o.port = i + 1; o.resp = out_resp[i]; o.data = out_data[i]; o.cyc = cyc;
          obs_q.push_back(o);
        end else if (out_data[i] !== '0) idle_data_viol++;
      end
      if (n > 1) multi_viol++;
    end
  end

  task automatic tick();
    @(negedge c_clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    repeat (n) tick();
  endtask

  task automatic send(input logic [3:0] mask, output int t);
    for (int i = 0; i < 4; i++) if (mask[i]) begin cmd_in[i] = req_cmd[i]; data_in[i] = req_a[i]; end
    t = cyc;
    tick();
    for (int i = 0; i < 4; i++) if (mask[i]) begin cmd_in[i] = '0; data_in[i] = req_b[i]; end
    tick();
    for (int i = 0; i < 4; i++) data_in[i] = $urandom();
  endtask

  task automatic wait_resps(input int base, input int n, input int budget);
    int k;
    k = 0;
    while (obs_q.size() < base + n && k < budget) begin tick(); k++; end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin cmd_in[i] = '0; data_in[i] = '0; end
    tick_n(2);
    reset = 1'b0;
    mon_en = 1'b1;
    model_last = 3;
    tick();
    for (int i = 0; i < 4; i++) begin
      total++; if (out_resp[i] !== 2'd0) begin bad++; $display("FAIL reset_resp%0d: got %0h want 0", i + 1, out_resp[i]); end
      total++; if (out_data[i] !== '0) begin bad++; $display("FAIL reset_data%0d: got %0h want 0", i + 1, out_data[i]); end
    end
    total++; if (alu_start !== 1'b0) begin bad++; $display("FAIL reset_start: got %0b want 0", alu_start); end
    total++; if (alu_cmd !== 4'd0) begin bad++; $display("FAIL reset_cmd: got %0h want 0", alu_cmd); end
    total++; if (alu_op1 !== '0) begin bad++; $display("FAIL reset_op1: got %0h want 0", alu_op1); end
    total++; if (alu_op2 !== '0) begin bad++; $display("FAIL reset_op2: got %0h want 0", alu_op2); end
  endtask

  task automatic test_single_add();
    int base, sb, t;
    obs_t o;
    alu_lat = 3;
    req_cmd[0] = 4'd1; req_a[0] = 32'h0000_0001; req_b[0] = 32'h01FF_FFFF;
    base = obs_q.size(); sb = start_cnt;
    send(4'b0001, t);
    wait_resps(base, 1, 40);
    tick_n(3);
    total++; if (start_cnt - sb != 1) begin bad++; $display("FAIL add_starts: got %0d want 1", start_cnt - sb); end
    total++; if (start_cyc - t != 3) begin bad++; $display("FAIL add_start_lat: got %0d want 3", start_cyc - t); end
    total++; if (st_cmd !== 4'd1) begin bad++; $display("FAIL add_alu_cmd: got %0h want 1", st_cmd); end
    total++; if (st_op1 !== 32'h1) begin bad++; $display("FAIL add_alu_op1: got %0h want 1", st_op1); end
    total++; if (st_op2 !== 32'h01FF_FFFF) begin bad++; $display("FAIL add_alu_op2: got %0h want 1ffffff", st_op2); end
    total++;
    if (obs_q.size() - base != 1) begin bad++; $display("FAIL add_resp_count: got %0d want 1", obs_q.size() - base); end
    else begin
      o = obs_q[base];
      total++; if (o.port != 1) begin bad++; $display("FAIL add_port: got %0d want 1", o.port); end
      total++; if (o.resp !== 2'd1) begin bad++; $display("FAIL add_resp: got %0d want 1", o.resp); end
      total++; if (o.data !== 32'h0200_0000) begin bad++; $display("FAIL add_data: got %0h want 2000000", o.data); end
      total++; if (o.cyc - start_cyc != 4) begin bad++; $display("FAIL add_resp_lat: got %0d want 4", o.cyc - start_cyc); end
    end
    model_last = 0;
  endtask

  task automatic test_contention();
    int base, t, p;
    int exp_order [6];
    logic [DW+1:0] e;
    obs_t o;
    test_reset();
    exp_order = '{1, 2, 3, 4, 1, 3};
    alu_lat = 2;
    for (int i = 0; i < 4; i++) begin req_cmd[i] = 4'd1; req_a[i] = $urandom(); req_b[i] = $urandom(); end
    base = obs_q.size();
    send(4'b1111, t);
    wait_resps(base, 4, 200);
    tick_n(3);
    send(4'b0101, t);
    wait_resps(base, 6, 100);
    tick_n(3);
    total++;
    if (obs_q.size() - base != 6) begin bad++; $display("FAIL cont_count: got %0d want 6", obs_q.size() - base); end
    else begin
      for (int k = 0; k < 6; k++) begin
        o = obs_q[base + k];
        p = exp_order[k];
        e = alu_model(4'd1, req_a[p - 1], req_b[p - 1]);
        total++; if (o.port != p) begin bad++; $display("FAIL cont_order[%0d]: got %0d want %0d", k, o.port, p); end
        total++; if ({o.resp, o.data} !== e) begin bad++; $display("FAIL cont_payload[%0d]: got %0h want %0h", k, {o.resp, o.data}, e); end
      end
    end
    model_last = 2;
  endtask

  task automatic test_timeout();
    int base, sb, t;
    logic [DW+1:0] e;
    obs_t o;
    alu_lat = 0;
    req_cmd[1] = 4'd1; req_a[1] = $urandom(); req_b[1] = $urandom();
    base = obs_q.size(); sb = start_cnt;
    send(4'b0010, t);
    wait_resps(base, 1, int'(TO) + 40);
    total++;
    if (obs_q.size() - base != 1) begin bad++; $display("FAIL to_count: got %0d want 1", obs_q.size() - base); end
    else begin
      o = obs_q[base];
      total++; if (o.port != 2) begin bad++; $display("FAIL to_port: got %0d want 2", o.port); end
      total++; if (o.resp !== 2'd3 || o.data !== '0) begin bad++; $display("FAIL to_payload: got %0d/%0h want 3/0", o.resp, o.data); end
      total++; if (o.cyc - start_cyc != int'(TO) + 1) begin bad++; $display("FAIL to_lat: got %0d want %0d", o.cyc - start_cyc, TO + 1); end
    end
    tick_n(3);
    alu_lat = 2;
    req_cmd[2] = 4'd2; req_a[2] = $urandom(); req_b[2] = $urandom();
    e = alu_model(4'd2, req_a[2], req_b[2]);
    base = obs_q.size();
    send(4'b0100, t);
    wait_resps(base, 1, 40);
    tick_n(3);
    total++; if (start_cnt - sb != 2) begin bad++; $display("FAIL to_starts: got %0d want 2", start_cnt - sb); end
    total++;
    if (obs_q.size() - base != 1) begin bad++; $display("FAIL to_next_count: got %0d want 1", obs_q.size() - base); end
    else begin
      o = obs_q[base];
      total++; if (o.port != 3 || {o.resp, o.data} !== e) begin bad++; $display("FAIL to_next: got p%0d %0h want p3 %0h", o.port, {o.resp, o.data}, e); end
    end
    model_last = 2;
  endtask

  task automatic test_invalid_cmd();
    int base, sb, t;
    logic [DW+1:0] e;
    int exp_starts;
    obs_t o;
    alu_lat = 2;
    req_cmd[0] = 4'd3; req_a[0] = $urandom(); req_b[0] = $urandom();
`ifdef CALC1_SCHED_CMD_FILTER_EN
    exp_starts = 0;
    e = {2'd2, 32'd0};
`else
    exp_starts = 1;
    e = alu_model(4'd3, req_a[0], req_b[0]);
`endif
    base = obs_q.size(); sb = start_cnt;
    send(4'b0001, t);
    wait_resps(base, 1, 40);
    tick_n(3);
    total++; if (start_cnt - sb != exp_starts) begin bad++; $display("FAIL inv_starts: got %0d want %0d", start_cnt - sb, exp_starts); end
    if (exp_starts == 1) begin
      total++; if (st_cmd !== 4'd3) begin bad++; $display("FAIL inv_alu_cmd: got %0h want 3", st_cmd); end
    end
    total++;
    if (obs_q.size() - base != 1) begin bad++; $display("FAIL inv_count: got %0d want 1", obs_q.size() - base); end
    else begin
      o = obs_q[base];
      total++; if (o.port != 1 || {o.resp, o.data} !== e) begin bad++; $display("FAIL inv_resp: got p%0d %0h want p1 %0h", o.port, {o.resp, o.data}, e); end
    end
    model_last = 0;
  endtask

  task automatic test_reset_mid_wait();
    int base, sb, t, k;
    logic [DW+1:0] e;
    obs_t o;
    alu_lat = 10;
    req_cmd[0] = 4'd1; req_a[0] = 32'h1234_5678; req_b[0] = 32'h0000_0010;
    base = obs_q.size(); sb = start_cnt;
    send(4'b0001, t);
    k = 0;
    while (start_cnt == sb && k < 20) begin tick(); k++; end
    total++; if (start_cnt - sb != 1) begin bad++; $display("FAIL rst_start_seen: got %0d want 1", start_cnt - sb); end
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++; if (alu_start !== 1'b0 || alu_cmd !== 4'd0) begin bad++; $display("FAIL rst_alu_ctl: got %0b/%0h want 0/0", alu_start, alu_cmd); end
    total++; if (alu_op1 !== '0 || alu_op2 !== '0) begin bad++; $display("FAIL rst_alu_ops: got %0h/%0h want 0/0", alu_op1, alu_op2); end
    for (int i = 0; i < 4; i++) begin
      total++; if (out_resp[i] !== 2'd0 || out_data[i] !== '0) begin bad++; $display("FAIL rst_out%0d: got %0d/%0h want 0/0", i + 1, out_resp[i], out_data[i]); end
    end
    tick_n(12);
    total++; if (obs_q.size() - base != 0) begin bad++; $display("FAIL rst_stale_done: got %0d responses want 0", obs_q.size() - base); end
    model_last = 3;
    alu_lat = 2;
    req_cmd[3] = 4'd2; req_a[3] = $urandom(); req_b[3] = $urandom();
    e = alu_model(4'd2, req_a[3], req_b[3]);
    sb = start_cnt;
    send(4'b1000, t);
    wait_resps(base, 1, 40);
    tick_n(3);
    total++; if (start_cnt - sb != 1 || start_cyc - t != 3) begin bad++; $display("FAIL rst_next_start: got n=%0d lat=%0d want n=1 lat=3", start_cnt - sb, start_cyc - t); end
    total++;
    if (obs_q.size() - base != 1) begin bad++; $display("FAIL rst_next_count: got %0d want 1", obs_q.size() - base); end
    else begin
      o = obs_q[base];
      total++; if (o.port != 4 || {o.resp, o.data} !== e) begin bad++; $display("FAIL rst_next: got p%0d %0h want p4 %0h", o.port, {o.resp, o.data}, e); end
    end
    model_last = 3;
  endtask

  task automatic test_ignored_cmd();
    int base, sb;
    logic [DW-1:0] a, b;
    logic [DW+1:0] e;
    obs_t o;
    alu_lat = 5;
    a = $urandom(); b = $urandom();
    e = alu_model(4'd1, a, b);
    base = obs_q.size(); sb = start_cnt;
    cmd_in[1] = 4'd1; data_in[1] = a;
    tick();
    data_in[1] = b;
    tick();
    data_in[1] = $urandom();
    tick_n(3);
    cmd_in[1] = 4'd0;
    wait_resps(base, 1, 40);
    tick_n(4);
    total++; if (start_cnt - sb != 1) begin bad++; $display("FAIL ign_starts: got %0d want 1", start_cnt - sb); end
    total++; if (st_op2 !== b) begin bad++; $display("FAIL ign_op2: got %0h want %0h", st_op2, b); end
    total++;
    if (obs_q.size() - base != 1) begin bad++; $display("FAIL ign_count: got %0d want 1", obs_q.size() - base); end
    else begin
      o = obs_q[base];
      total++; if (o.port != 2 || {o.resp, o.data} !== e) begin bad++; $display("FAIL ign_resp: got p%0d %0h want p2 %0h", o.port, {o.resp, o.data}, e); end
    end
    model_last = 1;
  endtask

  task automatic test_random();
    int base, sb, t, p, n;
    logic [3:0] mask;
    int order [$];
    logic [DW+1:0] e;
    obs_t o;
    for (int it = 0; it < 25; it++) begin
      mask = 4'($urandom_range(1, 15));
      alu_lat = $urandom_range(1, 6);
      for (int i = 0; i < 4; i++) begin
        req_cmd[i] = 4'($urandom_range(1, 2)); req_a[i] = $urandom(); req_b[i] = $urandom();
      end
      order.delete();
      for (int k = 1; k <= 4; k++) begin
        p = (model_last + k) % 4;
        if (mask[p]) order.push_back(p);
      end
      n = order.size();
      model_last = order[n - 1];
      base = obs_q.size(); sb = start_cnt;
      send(mask, t);
      wait_resps(base, n, 200);
      tick_n(3);
      total++; if (start_cnt - sb != n) begin bad++; $display("FAIL rnd%0d_starts: got %0d want %0d", it, start_cnt - sb, n); end
      total++;
      if (obs_q.size() - base != n) begin bad++; $display("FAIL rnd%0d_count: got %0d want %0d", it, obs_q.size() - base, n); end
      else begin
        for (int k = 0; k < n; k++) begin
          o = obs_q[base + k];
          p = order[k];
          e = alu_model(req_cmd[p], req_a[p], req_b[p]);
          total++; if (o.port != p + 1) begin bad++; $display("FAIL rnd%0d_order[%0d]: got %0d want %0d", it, k, o.port, p + 1); end
          total++; if ({o.resp, o.data} !== e) begin bad++; $display("FAIL rnd%0d_payload[%0d]: got %0h want %0h", it, k, {o.resp, o.data}, e); end
        end
      end
    end
    total++; if (multi_viol != 0) begin bad++; $display("FAIL multi_port_resp: got %0d cycles want 0", multi_viol); end
    total++; if (idle_data_viol != 0) begin bad++; $display("FAIL idle_data_nonzero: got %0d want 0", idle_data_viol); end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      cmd_in[i] = '0; data_in[i] = '0; req_cmd[i] = '0; req_a[i] = '0; req_b[i] = '0;
    end
    test_reset();
    test_single_add();
    test_contention();
    test_timeout();
    test_invalid_cmd();
    test_reset_mid_wait();
    test_ignored_cmd();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
